router_fsm: RTL

Packet-sequencing controller for the 1x3 router. It decodes the header address of an incoming packet and waits until the destination FIFO is empty. It then steps the datapath through header load, payload load, FIFO-full stall, parity load and parity check. Its state-decoded strobes drive the input register/parity block and the write-enable generation in router_sync.

---
 rtl/router_pkg.sv | 35 +++
 rtl/router_fsm_if.sv | 47 ++++
 rtl/router_fsm.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router packet-sequencing controller:
// state encoding, the invalid header address and the FIFO count.
package router_pkg;

    // Number of destination FIFOs behind the router
    localparam int FIFO_COUNT = 3;

    // Header address value that selects no FIFO
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Binary state encoding, kept as plain constants for legacy tools
    typedef logic [2:0] state_t;
    localparam state_t ST_DA  = 3'd0;  // DECODE_ADDRESS
    localparam state_t ST_LFD = 3'd1;  // LOAD_FIRST_DATA
    localparam state_t ST_LD  = 3'd2;  // LOAD_DATA
    localparam state_t ST_FFS = 3'd3;  // FIFO_FULL_STATE
    localparam state_t ST_LAF = 3'd4;  // LOAD_AFTER_FULL
    localparam state_t ST_LP  = 3'd5;  // LOAD_PARITY
    localparam state_t ST_CPE = 3'd6;  // CHECK_PARITY_ERROR
    localparam state_t ST_WTE = 3'd7;  // WAIT_TILL_EMPTY

    // Pick the per-FIFO flag for an address; the invalid address selects nothing
    function automatic logic fifo_bit(input logic [FIFO_COUNT-1:0] flags,
                                      input logic [1:0]            addr);
        logic r_bit;
        case (addr)
            2'd0:    r_bit = flags[0];
            2'd1:    r_bit = flags[1];
            2'd2:    r_bit = flags[2];
            default: r_bit = 1'b0;
        endcase
        return r_bit;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Signal bundle between the router FSM and its surroundings
// (register/parity block, router_sync and the packet source).
interface router_fsm_if;

    // Inputs to the FSM
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;

    // Strobes produced by the FSM
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic       drop_pkt;

    // FSM side
    modport slave (
        input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );

    // Environment side
    modport master (
        output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );

endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router. Decodes the header
// address, waits for the destination FIFO to drain, then walks the datapath
// through header, payload, full-stall, parity load and parity check.
// All strobes are Moore outputs decoded from the state register.
// Optional: define ROUTER_FSM_WAIT_TIMEOUT_EN to abandon a packet that has
// waited WAIT_TIMEOUT cycles for its FIFO to empty (drop_pkt pulses once).
module router_fsm
    import router_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    router_fsm_if.slave bus
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [1:0]              r_addr_q;
    logic [FIFO_COUNT-1:0]   w_empty_vec;
    logic [FIFO_COUNT-1:0]   w_soft_vec;
    logic                    w_hdr_empty;
    logic                    w_addr_empty;
    logic                    w_addr_soft;
    logic                    w_timeout;
    logic                    w_drop_next;

    assign w_empty_vec  = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign w_soft_vec   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign w_hdr_empty  = fifo_bit(w_empty_vec, bus.data_in);
    assign w_addr_empty = fifo_bit(w_empty_vec, r_addr_q);
    assign w_addr_soft  = fifo_bit(w_soft_vec, r_addr_q);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [7:0] r_timer;
    logic       r_drop_pkt;

    assign w_timeout = (r_timer == TIMEOUT_LAST);

    // Count cycles spent waiting for the destination FIFO to empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= 8'd0;
        end else if (r_state != ST_WTE && w_next_state == ST_WTE) begin
            r_timer <= 8'd0;
        end else if (r_state == ST_WTE) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    // Register the one-cycle drop indication for an abandoned packet
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_pkt <= 1'b0;
        end else begin
            r_drop_pkt <= w_drop_next;
        end
    end

    assign bus.drop_pkt = r_drop_pkt;
`else
    // Without the timeout the wait is unbounded and nothing is ever dropped
    logic [8:0] w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_unused_cfg = {w_drop_next, 8'(WAIT_TIMEOUT - 1)};
    assign bus.drop_pkt = 1'b0;
`endif

    // Next-state selection; a soft reset of the active FIFO overrides everything
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred
        w_next_state = r_state;
        w_drop_next  = 1'b0;
        case (r_state)
            ST_DA: begin
                if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
                    w_next_state = w_hdr_empty ? ST_LFD : ST_WTE;
                end
            end
            ST_LFD: w_next_state = ST_LD;
            ST_LD: begin
                if (bus.fifo_full) begin
                    w_next_state = ST_FFS;
                end else if (!bus.pkt_valid) begin
                    w_next_state = ST_LP;
                end
            end
            ST_FFS: begin
                if (!bus.fifo_full) begin
                    w_next_state = ST_LAF;
                end
            end
            ST_LAF: begin
                if (bus.parity_done) begin
                    w_next_state = ST_DA;
                end else if (bus.low_pkt_valid) begin
                    w_next_state = ST_LP;
                end else begin
                    w_next_state = ST_LD;
                end
            end
            ST_LP:  w_next_state = ST_CPE;
            ST_CPE: w_next_state = bus.fifo_full ? ST_FFS : ST_DA;
            ST_WTE: begin
                if (w_addr_empty) begin
                    w_next_state = ST_LFD;
                end else if (w_timeout) begin
                    w_next_state = ST_DA;
                    w_drop_next  = 1'b1;
                end
            end
            default: w_next_state = ST_DA;
        endcase
        if (r_state != ST_DA && w_addr_soft) begin
            w_next_state = ST_DA;
            w_drop_next  = 1'b0;
        end
    end

    // State register and header-address latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_DA;
            r_addr_q <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values
            r_state <= w_next_state;
            if (r_state == ST_DA && w_next_state != ST_DA) begin
                r_addr_q <= bus.data_in;
            end
        end
    end

    assign bus.detect_add    = (r_state == ST_DA);
    assign bus.lfd_state     = (r_state == ST_LFD);
    assign bus.ld_state      = (r_state == ST_LD);
    assign bus.laf_state     = (r_state == ST_LAF);
    assign bus.full_state    = (r_state == ST_FFS);
    assign bus.write_enb_reg = (r_state == ST_LD) || (r_state == ST_LP) || (r_state == ST_LAF);
    assign bus.rst_int_reg   = (r_state == ST_CPE);
    assign bus.busy          = (r_state != ST_DA) && (r_state != ST_LD);

endmodule
